// File: rtl/fb_pkg.sv
// fb_pkg: shared types and constants for the framebuffer arbiter.
//   FB_AW / FB_DW : default pixel address / data widths (800x480, 24-bit RGB)
//   pixel_t       : one {R,G,B} pixel
//   arb_state_t   : arbiter FSM state encoding
package fb_pkg;

   localparam int FB_AW = 19;
   localparam int FB_DW = 24;

   typedef logic [FB_DW-1:0] pixel_t;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      GNT_RD = 2'd1,
      GNT_WR = 2'd2
   } arb_state_t;

endpackage

// File: rtl/fb_arb_pick.sv
// fb_arb_pick: combinational priority/fairness selector.
//   rd_req, wr_req : pending requests
//   streak_full    : reads have used up their consecutive-grant allowance
//   gnt_rd, gnt_wr : one-hot (or zero) grant decision
// Reads win unless the read streak is exhausted, in which case a pending
// write is forced through.
module fb_arb_pick (
   input  logic rd_req,
   input  logic wr_req,
   input  logic streak_full,
   output logic gnt_rd,
   output logic gnt_wr
);

   assign gnt_wr = wr_req & (~rd_req | streak_full);
   assign gnt_rd = rd_req & ~gnt_wr;

endmodule

// File: rtl/fb_arbiter.sv
// fb_arbiter: shares one single-port framebuffer memory port between the
// display refresh read path and the pixel writer (pixel_clk domain).
//   pixel_clk, pixel_rst          : clock, synchronous active-high reset
//   rd_req/rd_addr -> rd_ack/rd_data      : display read port
//   wr_req/wr_addr/wr_data -> wr_ack      : pixel write port
//   mem_req/mem_we/mem_addr/mem_wdata     : registered memory request
//   mem_ack/mem_rdata                     : memory completion / read data
//   err                                   : one-cycle timeout-abort pulse
// Optional macro FB_ARB_TIMEOUT_EN: abort a transaction after TIMEOUT
// cycles without mem_ack; otherwise err is 0 and the arbiter waits forever.
//
// state  | meaning
// IDLE   | no transaction; arbitrate rd_req / wr_req each cycle
// GNT_RD | read request on the memory port, waiting for mem_ack
// GNT_WR | write request on the memory port, waiting for mem_ack
module fb_arbiter
   import fb_pkg::*;
#(
   parameter int AW           = FB_AW,
   parameter int DW           = FB_DW,
   parameter int RD_BURST_MAX = 8,
   parameter int TIMEOUT      = 255
) (
   input  logic          pixel_clk,
   input  logic          pixel_rst,
   input  logic          rd_req,
   input  logic [AW-1:0] rd_addr,
   output logic          rd_ack,
   output logic [DW-1:0] rd_data,
   input  logic          wr_req,
   input  logic [AW-1:0] wr_addr,
   input  logic [DW-1:0] wr_data,
   output logic          wr_ack,
   output logic          mem_req,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   input  logic          mem_ack,
   input  logic [DW-1:0] mem_rdata,
   output logic          err
);

   localparam int SW = $clog2(RD_BURST_MAX + 1);
   localparam logic [SW-1:0] STREAK_MAX = SW'(RD_BURST_MAX);

   arb_state_t    state_q, state_d;
   logic [SW-1:0] streak_q, streak_d;
   logic          mem_req_d, mem_we_d;
   logic [AW-1:0] mem_addr_d;
   logic [DW-1:0] mem_wdata_d;
   logic          streak_full;
   logic          gnt_rd, gnt_wr;

`ifdef FB_ARB_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT + 1);
   localparam logic [TW-1:0] TMR_MAX = TW'(TIMEOUT);

   logic [TW-1:0] tmr_q, tmr_d;
   logic          err_q, err_d;

   assign err = err_q;
`else
   logic unused_timeout;

   assign unused_timeout = (TIMEOUT > 0);
   assign err            = 1'b0;
`endif

   assign streak_full = (streak_q == STREAK_MAX);

   fb_arb_pick u_pick (
      .rd_req      (rd_req),
      .wr_req      (wr_req),
      .streak_full (streak_full),
      .gnt_rd      (gnt_rd),
      .gnt_wr      (gnt_wr)
   );

   // Acks are only meaningful while a grant is outstanding; a stray mem_ack
   // in IDLE (or after a timeout abort) is dropped here.
   assign rd_ack  = (state_q == GNT_RD) & mem_ack;
   assign wr_ack  = (state_q == GNT_WR) & mem_ack;
   assign rd_data = mem_rdata;

   always_comb begin
      state_d     = state_q;
      streak_d    = streak_q;
      mem_req_d   = mem_req;
      mem_we_d    = mem_we;
      mem_addr_d  = mem_addr;
      mem_wdata_d = mem_wdata;
`ifdef FB_ARB_TIMEOUT_EN
      tmr_d       = tmr_q;
      err_d       = 1'b0;
`endif
      unique case (state_q)
         IDLE: begin
`ifdef FB_ARB_TIMEOUT_EN
            tmr_d = '0;
`endif
            if (gnt_wr) begin
               state_d     = GNT_WR;
               mem_req_d   = 1'b1;
               mem_we_d    = 1'b1;
               mem_addr_d  = wr_addr;
               mem_wdata_d = wr_data;
               streak_d    = '0;
            end else if (gnt_rd) begin
               state_d    = GNT_RD;
               mem_req_d  = 1'b1;
               mem_we_d   = 1'b0;
               mem_addr_d = rd_addr;
               // Only reads that make a waiting writer wait count toward the
               // streak; an uncontested read restarts it.
               if (!wr_req)
                  streak_d = '0;
               else if (!streak_full)
                  streak_d = streak_q + 1'b1;
            end
         end
         GNT_RD, GNT_WR: begin
            if (mem_ack) begin
               state_d   = IDLE;
               mem_req_d = 1'b0;
            end
`ifdef FB_ARB_TIMEOUT_EN
            else if (tmr_q == TMR_MAX) begin
               state_d   = IDLE;
               mem_req_d = 1'b0;
               err_d     = 1'b1;
            end else begin
               tmr_d = tmr_q + 1'b1;
            end
`endif
         end
         default: begin
            state_d   = IDLE;
            mem_req_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge pixel_clk) begin
      if (pixel_rst) begin
         state_q   <= IDLE;
         streak_q  <= '0;
         mem_req   <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
`ifdef FB_ARB_TIMEOUT_EN
         tmr_q     <= '0;
         err_q     <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         streak_q  <= streak_d;
         mem_req   <= mem_req_d;
         mem_we    <= mem_we_d;
         mem_addr  <= mem_addr_d;
         mem_wdata <= mem_wdata_d;
`ifdef FB_ARB_TIMEOUT_EN
         tmr_q     <= tmr_d;
         err_q     <= err_d;
`endif
      end
   end

endmodule

// File: tb/tb_fb_arbiter.sv
// tb_fb_arbiter: scoreboard bench for fb_arbiter with a latency-programmable
// memory model and two queued requesters. Timeout scenario runs only when
// FB_ARB_TIMEOUT_EN is defined.
module tb_fb_arbiter;

   localparam int AW           = 19;
   localparam int DW           = 24;
   localparam int RD_BURST_MAX = 8;
   localparam int TIMEOUT      = 16;

   logic          pixel_clk, pixel_rst;
   logic          rd_req, rd_ack, wr_req, wr_ack;
   logic [AW-1:0] rd_addr, wr_addr, mem_addr;
   logic [DW-1:0] rd_data, wr_data, mem_wdata, mem_rdata;
   logic          mem_req, mem_we, mem_ack, err;

   fb_arbiter #(
      .AW           (AW),
      .DW           (DW),
      .RD_BURST_MAX (RD_BURST_MAX),
      .TIMEOUT      (TIMEOUT)
   ) u_dut (
      .pixel_clk (pixel_clk),
      .pixel_rst (pixel_rst),
      .rd_req    (rd_req),
      .rd_addr   (rd_addr),
      .rd_ack    (rd_ack),
      .rd_data   (rd_data),
      .wr_req    (wr_req),
      .wr_addr   (wr_addr),
      .wr_data   (wr_data),
      .wr_ack    (wr_ack),
      .mem_req   (mem_req),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_ack   (mem_ack),
      .mem_rdata (mem_rdata),
      .err       (err)
   );

   initial pixel_clk = 1'b0;
   always #5 pixel_clk = ~pixel_clk;

   typedef struct {
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
      int            issue_cyc;
   } txn_t;

   txn_t rd_list[$], wr_list[$], rd_exp[$], wr_exp[$];
   bit   exp_kind[$];   // grant order, 1 = write

   int n_checks, n_fail, cyc, lat_cnt, mem_lat, err_cnt, err_cyc, rise_cyc;
   bit never_ack, force_ack, chk_latency, req_prev, ack_prev;
   bit last_rd_ack, last_wr_ack, mem_req_at_err;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got=0x%0h expected=0x%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   function automatic logic [DW-1:0] mem_val(input logic [AW-1:0] a);
      if (a == 19'h00010) return 24'hFF00FF;
      return (24'(a) * 24'd7) ^ 24'hA5C3E1;
   endfunction

   task automatic step();
      txn_t t;
      bit   k;
      @(posedge pixel_clk);
      #1;
      cyc++;
      if (ack_prev) chk("mem_req_drop_after_ack", mem_req, 1'b0);
      if (mem_req && !req_prev) begin
         rise_cyc = cyc;
         if (exp_kind.size() == 0) begin
            chk("grant_unexpected", 1'b1, 1'b0);
         end else begin
            k = exp_kind.pop_front();
            chk("grant_kind_we", mem_we, k);
            if (k) begin
               if (wr_exp.size() == 0) chk("grant_wr_no_req", 1'b1, 1'b0);
               else begin
                  chk("grant_wr_addr", mem_addr, wr_exp[0].addr);
                  chk("grant_wr_data", mem_wdata, wr_exp[0].data);
                  if (chk_latency) chk("grant_wr_delay", cyc - wr_exp[0].issue_cyc, 1);
               end
            end else begin
               if (rd_exp.size() == 0) chk("grant_rd_no_req", 1'b1, 1'b0);
               else begin
                  chk("grant_rd_addr", mem_addr, rd_exp[0].addr);
                  if (chk_latency) chk("grant_rd_delay", cyc - rd_exp[0].issue_cyc, 1);
               end
            end
         end
      end
      req_prev = mem_req;
      // memory model: ack in the mem_lat-th cycle of an outstanding request
      mem_ack   = 1'b0;
      mem_rdata = 24'h5A5A5A;
      if (!mem_req) begin
         lat_cnt = 0;
         if (force_ack) mem_ack = 1'b1;
      end else begin
         lat_cnt++;
         if (lat_cnt == mem_lat && !never_ack) begin
            mem_ack   = 1'b1;
            mem_rdata = mem_val(mem_addr);
         end
      end
      #1;
      last_rd_ack = rd_ack;
      last_wr_ack = wr_ack;
      if (rd_ack && wr_ack) chk("dual_ack", 1'b1, 1'b0);
      if (rd_ack) begin
         if (rd_exp.size() == 0) chk("rd_ack_spurious", 1'b1, 1'b0);
         else begin
            t = rd_exp.pop_front();
            chk("rd_data", rd_data, t.data);
         end
      end
      if (wr_ack && wr_exp.size() == 0) chk("wr_ack_spurious", 1'b1, 1'b0);
      else if (wr_ack) void'(wr_exp.pop_front());
      ack_prev = rd_ack | wr_ack;
      if (err) begin
         err_cnt++;
         err_cyc        = cyc;
         mem_req_at_err = mem_req;
         if (rd_req) begin
            rd_req = 1'b0;
            if (rd_exp.size() > 0) void'(rd_exp.pop_front());
         end
      end
      // requesters: hold until ack, then issue the next queued item at once
      if (rd_ack) rd_req = 1'b0;
      if (wr_ack) wr_req = 1'b0;
      if (!rd_req && rd_list.size() > 0) begin
         t = rd_list.pop_front();
         t.issue_cyc = cyc;
         rd_addr = t.addr;
         rd_req  = 1'b1;
         rd_exp.push_back(t);
      end
      if (!wr_req && wr_list.size() > 0) begin
         t = wr_list.pop_front();
         t.issue_cyc = cyc;
         wr_addr = t.addr;
         wr_data = t.data;
         wr_req  = 1'b1;
         wr_exp.push_back(t);
      end
   endtask

   task automatic run_until_idle(input int max_cyc);
      bit done;
      done = 1'b0;
      for (int i = 0; i < max_cyc && !done; i++) begin
         step();
         done = (rd_list.size() == 0) && (wr_list.size() == 0) && (rd_exp.size() == 0) &&
                (wr_exp.size() == 0) && !rd_req && !wr_req && !mem_req;
      end
      if (!done) chk("drain_timeout", 1'b0, 1'b1);
   endtask

   task automatic wait_rise(input int max_cyc);
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < max_cyc && !seen; i++) begin
         step();
         seen = mem_req;
      end
      if (!seen) chk("mem_req_rise_timeout", 1'b0, 1'b1);
   endtask

   initial begin
      txn_t t;
      n_checks = 0; n_fail = 0; cyc = 0; lat_cnt = 0; mem_lat = 1; err_cnt = 0;
      err_cyc = 0; rise_cyc = 0; never_ack = 0; force_ack = 0; chk_latency = 0;
      req_prev = 0; ack_prev = 0; mem_req_at_err = 0;
      pixel_rst = 1'b1; rd_req = 0; wr_req = 0; rd_addr = '0; wr_addr = '0; wr_data = '0;
      mem_ack = 0; mem_rdata = '0;
      repeat (3) step();
      chk("rst_mem_req",   mem_req,   1'b0);
      chk("rst_mem_we",    mem_we,    1'b0);
      chk("rst_mem_addr",  mem_addr,  '0);
      chk("rst_mem_wdata", mem_wdata, '0);
      chk("rst_err",       err,       1'b0);
      chk("rst_rd_ack",    rd_ack,    1'b0);
      chk("rst_wr_ack",    wr_ack,    1'b0);
      pixel_rst = 1'b0;
      step();

      // single read, latency 3
      chk_latency = 1; mem_lat = 3;
      t.addr = 19'h00010; t.data = 24'hFF00FF; t.issue_cyc = 0;
      rd_list.push_back(t); exp_kind.push_back(1'b0);
      run_until_idle(50);

      // single write, latency 1
      mem_lat = 1;
      t.addr = 19'h5DBFF; t.data = 24'h123456;
      wr_list.push_back(t); exp_kind.push_back(1'b1);
      run_until_idle(50);

      // contention: 8 reads then 1 write, repeating, 99 transactions
      chk_latency = 0; mem_lat = 2;
      for (int b = 0; b < 11; b++) begin
         for (int r = 0; r < RD_BURST_MAX; r++) begin
            t.addr = 19'(b * 64 + r + 19'h100);
            t.data = mem_val(t.addr);
            rd_list.push_back(t);
            exp_kind.push_back(1'b0);
         end
         t.addr = 19'(19'h40000 + b);
         t.data = 24'($urandom);
         wr_list.push_back(t);
         exp_kind.push_back(1'b1);
      end
      run_until_idle(2000);

      // reset mid-read, latency 5, then a normal read
      chk_latency = 1; mem_lat = 5;
      t.addr = 19'h01234; t.data = mem_val(t.addr);
      rd_list.push_back(t); exp_kind.push_back(1'b0);
      wait_rise(10);
      step();
      pixel_rst = 1'b1;
      rd_req    = 1'b0;
      if (rd_exp.size() > 0) void'(rd_exp.pop_front());
      step();
      chk("rst_mid_mem_req", mem_req, 1'b0);
      pixel_rst = 1'b0;
      mem_lat = 2;
      t.addr = 19'h00777; t.data = mem_val(t.addr);
      rd_list.push_back(t); exp_kind.push_back(1'b0);
      run_until_idle(50);

      // mem_ack while idle
      force_ack = 1;
      step();
      force_ack = 0;
      chk("idle_ack_rd_ack", last_rd_ack, 1'b0);
      chk("idle_ack_wr_ack", last_wr_ack, 1'b0);
      step();
      chk("idle_ack_mem_req", mem_req, 1'b0);
      step();
      chk("idle_ack_mem_req2", mem_req, 1'b0);

`ifdef FB_ARB_TIMEOUT_EN
      // memory never acks: abort after TIMEOUT, then pending write proceeds
      chk_latency = 0; never_ack = 1; mem_lat = 2;
      t.addr = 19'h00200; t.data = mem_val(t.addr);
      rd_list.push_back(t); exp_kind.push_back(1'b0);
      wait_rise(10);
      t.addr = 19'h00300; t.data = 24'hABCDEF;
      wr_list.push_back(t); exp_kind.push_back(1'b1);
      for (int i = 0; i < 40 && err_cnt == 0; i++) step();
      chk("timeout_err_seen", err_cnt, 1);
      chk("timeout_err_delay", err_cyc - rise_cyc, TIMEOUT + 1);
      chk("timeout_mem_req", mem_req_at_err, 1'b0);
      never_ack = 0;
      run_until_idle(50);
      chk("timeout_err_once", err_cnt, 1);
`else
      chk("err_never", err_cnt, 0);
`endif

      chk("kinds_left", exp_kind.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/fb_arbiter.md
Name: fb_arbiter

Overview:
- Single-clock arbiter sharing one single-port framebuffer memory port between two requesters.
- Requester 1 is the display refresh read path, which feeds the VGA timing generator.
- Requester 2 is the pixel writer (pattern generator or CPU bridge).
- Reads have priority, but writes are guaranteed progress after a bounded number of consecutive read grants.
- Sits between the display fetch logic / writer and the framebuffer memory controller, in the pixel_clk domain.

Parameters:
AW, 19, address width in pixels (800*480 = 384000 < 2^19)
DW, 24, pixel data width ({R,G,B} 8 bits each)
RD_BURST_MAX, 8, max consecutive read grants while a write is pending (>= 1)
TIMEOUT, 255, max cycles waiting for mem_ack before abort (used only with FB_ARB_TIMEOUT_EN)

Ports:
pixel_clk  in  1  clock
pixel_rst  in  1  synchronous active-high reset
rd_req  in  1  display read request; held with rd_addr stable until rd_ack
rd_addr  in  AW  display read address
rd_ack  out  1  one-cycle read completion pulse
rd_data  out  DW  read data, valid when rd_ack=1
wr_req  in  1  write request; held with wr_addr/wr_data stable until wr_ack
wr_addr  in  AW  write address
wr_data  in  DW  write data
wr_ack  out  1  one-cycle write completion pulse
mem_req  out  1  memory request, held until mem_ack
mem_we  out  1  1 = write, 0 = read
mem_addr  out  AW  memory address
mem_wdata  out  DW  memory write data
mem_ack  in  1  one-cycle completion from memory; mem_rdata valid the same cycle
mem_rdata  in  DW  memory read data
err  out  1  one-cycle pulse on timeout abort (held 0 without the optional feature)

Behaviour:
- FSM states: IDLE, GNT_RD, GNT_WR. Reset: state=IDLE, streak=0.
- Reset values of registered outputs: mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, err=0.
- rd_ack and wr_ack are combinational: rd_ack = (state==GNT_RD) & mem_ack; wr_ack = (state==GNT_WR) & mem_ack.
- rd_data = mem_rdata, passed through unregistered.
- IDLE arbitration, evaluated each cycle:
  - Only rd_req high -> GNT_RD.
  - Only wr_req high -> GNT_WR.
  - Both high -> GNT_WR if streak == RD_BURST_MAX, else GNT_RD.
  - Neither high -> stay in IDLE.
- On the grant transition, register mem_req=1, mem_we (1 for write), mem_addr and mem_wdata (write only) from the winner. The request therefore appears one cycle after the winning cycle in IDLE.
- Streak counter:
  - Read grant while wr_req=1 -> streak+1, saturating at RD_BURST_MAX.
  - Write grant, or read grant with wr_req=0 -> streak=0.
- GNT_x state:
  - Hold mem_* stable until mem_ack.
  - On mem_ack: requester ack pulses the same cycle; mem_req=0 and state=IDLE next cycle.
  - Minimum transaction period is therefore 2 + memory latency cycles.
- mem_ack arriving in IDLE is ignored: no ack is generated.
- A requester dropping its req before ack is a protocol violation; the arbiter completes the memory access and the ack pulse is still emitted.
- Reset mid-transaction: state returns to IDLE and mem_req drops the next cycle with no ack. The memory controller shares pixel_rst.
- Width rules:
  - streak is $clog2(RD_BURST_MAX+1) bits.
  - Timeout counter is $clog2(TIMEOUT+1) bits.

Optional Feature:
- Macro FB_ARB_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to GNT_x and increments each cycle without mem_ack.
  - When it reaches TIMEOUT, the next cycle gives: err=1 for one cycle, mem_req=0, state=IDLE, no rd_ack/wr_ack.
  - mem_ack on the same cycle the count reaches TIMEOUT wins: normal completion, no err.
- Undefined: err is tied to 0, no counter is instantiated, and the arbiter waits indefinitely.

Decomposition:
- Package fb_pkg:
  - typedef enum arb_state_t {IDLE, GNT_RD, GNT_WR}.
  - Localparams FB_AW=19, FB_DW=24.
  - typedef pixel_t = logic [23:0].
- Sub-module fb_arb_pick: combinational priority/fairness selector. Inputs rd_req, wr_req, streak_full; outputs gnt_rd, gnt_wr. Reusable for future extra requesters.

Test Plan:
- rd_req=1, rd_addr=0x00010, memory latency 3, mem_rdata=0xFF00FF -> mem_req rises 1 cycle after the request, mem_we=0, rd_ack pulses once with rd_data=0xFF00FF; no wr_ack.
- wr_req=1, wr_addr=0x5DBFF, wr_data=0x123456, latency 1 -> mem_we=1, mem_addr=0x5DBFF, mem_wdata=0x123456; wr_ack 1 cycle wide; mem_req back to 0 the cycle after.
- rd_req and wr_req held at 1 continuously, RD_BURST_MAX=8 -> grant sequence is 8 reads, 1 write, repeating; no starvation over 100 transactions.
- pixel_rst asserted 2 cycles into a read with latency 5 -> mem_req=0 and state=IDLE the next cycle; no rd_ack; the next request after reset is granted normally.
- With FB_ARB_TIMEOUT_EN, TIMEOUT=16, memory never acks -> err pulses once 17 cycles after mem_req rises; mem_req=0; a pending wr_req is then granted.
- mem_ack pulsed while in IDLE -> no rd_ack/wr_ack and no state change.
